uart_fifo_seq_ctrl: RTL and testbench

- Controller that sequences one 256x8 UART FIFO between a host-side byte writer and the UART transmitter.
- Gates writes against full and tracks occupancy.
- Schedules single-byte reads and compensates for the FIFO's registered read path.
- Presents each byte to the transmitter over a valid/ready handshake.
- Drives the almost-full level and status flags used by the core's register interface.

---
 rtl/uart_fifo_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_fifo_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_seq_ctrl.sv
// rtl/uart_fifo_seq_ctrl.sv - write gating, occupancy tracking and read sequencing for one UART byte FIFO
module uart_fifo_seq_ctrl #(
  parameter int         DEPTH      = 256,
  parameter int         RD_LATENCY = 2,
  parameter logic [7:0] LEVEL      = 8'd255
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wr_req,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ack,
  input  logic                       level_ld,
  input  logic [7:0]                 level_in,
  output logic                       fifo_we,
  output logic [7:0]                 fifo_di,
  output logic                       fifo_re,
  input  logic [7:0]                 fifo_do,
  input  logic                       fifo_empty,
  input  logic                       fifo_full,
  output logic [7:0]                 fifo_level,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clr_status
);

  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      lat_q, lat_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            full_i;
  logic            wr_ok;
  logic            rd_avail;

  // Write gating, occupancy and status; count already excludes a byte once it is strobed out.
  always_comb begin
    full_i     = (count_q == CW'(DEPTH)) | fifo_full;
    wr_ok      = wr_req & ~full_i;
    overflow_d = (overflow_q & ~clr_status) | (wr_req & full_i);
    level_d    = level_ld ? level_in : level_q;
    count_d    = count_q + CW'(wr_ok) - CW'(fifo_re);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q    <= '0;
      level_q    <= LEVEL;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // WAIT spans RD_LATENCY cycles so the capture lines up with the FIFO's two-stage read path.
  always_comb begin
    rd_avail   = (count_q != '0) & ~fifo_empty;
    state_d    = state_q;
    lat_d      = lat_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: if (rd_avail) state_d = READ;
      READ: begin
        state_d = WAIT;
        lat_d   = LAT_INIT;
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          tx_data_d  = fifo_do;
          tx_valid_d = 1'b1;
          state_d    = HOLD;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = rd_avail ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_re = (state_q == READ);
  end

  assign wr_ack      = wr_ok;
  assign fifo_we     = wr_ok;
  assign fifo_di     = wr_data;
  assign fifo_level  = level_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(level_q));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_fifo_seq_ctrl.sv
// tb/tb_uart_fifo_seq_ctrl.sv - scoreboard bench for uart_fifo_seq_ctrl with a behavioural 256x8 FIFO
module tb_uart_fifo_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack;
  logic       level_ld = 1'b0;
  logic [7:0] level_in = 8'h00;
  logic       fifo_we;
  logic [7:0] fifo_di;
  logic       fifo_re;
  logic [7:0] fifo_do;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_level;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic [8:0] count;
  logic       almost_full;
  logic       overflow;
  logic       clr_status = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         mcount = 0;
  logic       ovf_m = 1'b0;
  logic [7:0] lvl_m = 8'hFF;
  logic       exp_acc = 1'b0;

  logic [7:0] mem [0:255];
  int         occ = 0;
  int         wp = 0;
  int         rp = 0;
  logic [7:0] out_r = 8'h00;
  logic [7:0] do_r = 8'h00;

  uart_fifo_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .level_ld(level_ld), .level_in(level_in),
    .fifo_we(fifo_we), .fifo_di(fifo_di), .fifo_re(fifo_re), .fifo_do(fifo_do),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .count(count), .almost_full(almost_full), .overflow(overflow),
    .clr_status(clr_status)
  );

  always #5 CLK = ~CLK;

  assign fifo_empty = (occ == 0);
  assign fifo_full  = (occ == 256);
  assign fifo_do    = do_r;

  // FIFO with output register plus wrapper DO register, and reference count/status models
  always @(posedge CLK) begin
    if (RESET) begin
      occ <= 0; wp <= 0; rp <= 0; out_r <= 8'h00; do_r <= 8'h00;
      mcount <= 0; ovf_m <= 1'b0; lvl_m <= 8'hFF;
    end else begin
      if (fifo_we) begin
        mem[wp] <= fifo_di;
        wp <= (wp + 1) % 256;
      end
      if (fifo_re) begin
        out_r <= mem[rp];
        rp <= (rp + 1) % 256;
      end
      do_r   <= out_r;
      occ    <= occ + (fifo_we ? 1 : 0) - (fifo_re ? 1 : 0);
      mcount <= mcount + (exp_acc ? 1 : 0) - (fifo_re ? 1 : 0);
      ovf_m  <= (ovf_m & ~clr_status) | (wr_req & (mcount == 256));
      if (level_ld) lvl_m <= level_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      check("count", count, mcount);
      check("overflow", overflow, ovf_m);
      check("fifo_level", fifo_level, lvl_m);
      check("almost_full", almost_full, (mcount >= int'(lvl_m)));
      check("wr_ack", wr_ack, exp_acc);
      check("fifo_we", fifo_we, exp_acc);
      if (exp_acc) check("fifo_di", fifo_di, wr_data);
      if (fifo_re) check("re_nonempty", (occ != 0), 1);
      if (tx_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_tx actual=valid data=%0h required=no byte at %0t", tx_data, $time);
        end else begin
          check("tx_data", tx_data, sb[0]);
          if (tx_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic req, input logic [7:0] d);
    wr_req  = req;
    wr_data = d;
    exp_acc = req && (mcount < 256);
    if (exp_acc) sb.push_back(d);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    tx_ready = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      cyc();
      if (sb.size() == 0 && !tx_valid) done = 1'b1;
    end
    check({name, "_drained"}, done, 1);
    #1;
    check({name, "_count_zero"}, count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int acc;
    repeat (3) cyc();
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      check("idle_fifo_re", fifo_re, 0);
      check("idle_tx_valid", tx_valid, 0);
      check("idle_count", count, 0);
      check("idle_level", fifo_level, 8'hFF);
      check("idle_overflow", overflow, 0);
      check("idle_tx_data", tx_data, 0);
    end

    tx_ready = 1'b1;
    cyc(); drive(1'b1, 8'hA5); #1;
    check("a5_wr_ack", wr_ack, 1);
    check("a5_fifo_di", fifo_di, 8'hA5);
    cyc(); drive(1'b0, 8'h00); #1;
    check("a5_c1_re", fifo_re, 0);
    check("a5_c1_count", count, 1);
    cyc(); #1;
    check("a5_c2_re", fifo_re, 1);
    cyc(); #1;
    check("a5_c3_valid", tx_valid, 0);
    check("a5_c3_count", count, 0);
    cyc(); #1;
    check("a5_c4_valid", tx_valid, 0);
    cyc(); #1;
    check("a5_c5_valid", tx_valid, 1);
    check("a5_c5_data", tx_data, 8'hA5);
    cyc(); #1;
    check("a5_c6_valid", tx_valid, 0);
    check("a5_c6_count", count, 0);

    tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cyc(); drive(1'b1, 8'(i));
    end
    cyc(); drive(1'b0, 8'h00); #1;
    check("fill_count_255", count, 255);
    cyc(); drive(1'b1, 8'hEE); #1;
    check("fill_last_ack", wr_ack, 1);
    cyc(); drive(1'b1, 8'hEF); #1;
    check("fill_full_count", count, 256);
    check("fill_reject_ack", wr_ack, 0);
    cyc(); drive(1'b0, 8'h00); #1;
    check("fill_overflow_set", overflow, 1);
    cyc(); clr_status = 1'b1;
    cyc(); clr_status = 1'b0; #1;
    check("fill_overflow_clr", overflow, 0);
    cyc(); clr_status = 1'b1; drive(1'b1, 8'hEF);
    cyc(); clr_status = 1'b0; drive(1'b0, 8'h00); #1;
    check("clr_vs_new_ovf", overflow, 1);
    cyc(); clr_status = 1'b1;
    cyc(); clr_status = 1'b0; #1;
    check("fill_overflow_clr2", overflow, 0);
    drain("fill");

    cyc(); level_ld = 1'b1; level_in = 8'd4;
    cyc(); level_ld = 1'b0; #1;
    check("lvl4_fifo_level", fifo_level, 8'd4);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); drive(1'b1, 8'(8'h10 + i));
      if (i == 4) begin
        #1;
        check("lvl4_count3", count, 3);
        check("lvl4_af_low", almost_full, 0);
      end
    end
    cyc(); drive(1'b0, 8'h00); #1;
    check("lvl4_count4", count, 4);
    check("lvl4_af_high", almost_full, 1);
    drain("lvl4");
    cyc(); level_ld = 1'b1; level_in = 8'd0;
    cyc(); level_ld = 1'b0; #1;
    check("lvl0_af_const", almost_full, 1);
    cyc(); level_ld = 1'b1; level_in = 8'hFF;
    cyc(); level_ld = 1'b0; #1;
    check("lvl255_af", almost_full, 0);

    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      cyc();
      tx_ready = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) == 0, 8'($urandom));
      if (exp_acc) acc++;
    end
    cyc(); drive(1'b0, 8'h00);
    check("stream_accepted", acc, 1000);
    drain("stream");

    tx_ready = 1'b1;
    cyc(); drive(1'b1, 8'h5A);
    cyc(); drive(1'b0, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc(); #1;
      if (fifo_re) seen = 1'b1;
    end
    check("rst_read_seen", seen, 1);
    cyc(); RESET = 1'b1; sb.delete();
    cyc(); RESET = 1'b0; #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_count", count, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check("rst_no_stale", tx_valid, 0);
    end
    cyc(); drive(1'b1, 8'h3C);
    cyc(); drive(1'b0, 8'h00);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
